dr_load_arbiter: RTL and testbench
==================================

// Module: dr_load_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that shares the 8-bit data register (DR) load path between NREQ requesters
//  (e.g. memory read, ALU writeback, I/O port, control unit).
//  Captures the winner's byte, drives it onto the DR input with a one-cycle load strobe, then acks the winner.
//  Sits between the requesters and the DR; it is the only driver of the DR load strobe.
// PARAMETERS
//  NREQ  4  number of requesters (2..8)
//  DW    8  data width of the DR path
// PORTS
//  clk         in   1        system clock, all state on rising edge
//  rst         in   1        asynchronous, active-low reset
//  arb_en      in   1        1 = arbitration allowed; 0 = no new grant starts
//  req         in   NREQ     per-requester load request, level, held until ack
//  req_data    in   NREQ*DW  packed data, requester i at [i*DW +: DW]
//  gnt         out  NREQ     one-hot, requester currently owning DR path
//  ack         out  NREQ     one-hot 1-cycle pulse: requester's byte written into DR
//  data_on_dr  out  1        DR load strobe (1 cycle)
//  bus_2_dr    out  DW       byte presented to DR
//  busy        out  1        1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, gnt=0, ack=0, data_on_dr=0, bus_2_dr=0, busy=0, rr_ptr=0.
//  - FSM states: IDLE, LOAD, ACK.
//  - IDLE: if arb_en && |req_eff -> LOAD. On that edge: winner latched, bus_2_dr<=req_data[winner], gnt<=onehot(winner).
//  - LOAD (1 cycle): data_on_dr=1, gnt held, bus_2_dr stable; DR captures at end of cycle. -> ACK.
//  - ACK (1 cycle): ack[winner]=1, gnt=0, data_on_dr=0.
//    If arb_en && |req_eff -> LOAD, latching a new winner on this edge; else -> IDLE.
//    bus_2_dr holds its last value until the next capture.
//  - req_eff = req, except in ACK, where the bit of the requester being acked is masked.
//    The requester must drop req on the cycle after ack.
//  - Winner: first set bit of req_eff, searching upward from rr_ptr with wrap (NREQ-1 -> 0).
//    rr_ptr <= (winner+1) mod NREQ on each capture.
//  - Latency: req seen in IDLE at edge t -> data_on_dr during cycle t+1 -> ack during cycle t+2.
//    Back-to-back loads: one per 2 cycles.
//  - req data is sampled only at the capture edge; later changes to req_data do not affect the current load.
//  - A req dropped before capture is simply not granted. A req dropped after capture still completes LOAD/ACK.
//  - arb_en=0 in LOAD/ACK: the current transaction completes; no new capture happens.
//  - Simultaneous requests: exactly one winner per capture; no requester waits more than NREQ-1 grants.
//  - Reset mid-LOAD: data_on_dr drops immediately (async); no ack is issued; rr_ptr=0.
//  - Invariants: gnt and ack each at most one-hot; data_on_dr == (state==LOAD); ack never coincides with data_on_dr.
// TESTING
//  1 Single: req=0001, req_data[7:0]=8'hA5 -> cycle+1: data_on_dr=1, bus_2_dr=A5, gnt=0001;
//    cycle+2: ack=0001; then IDLE.
//  2 All req=1111 held, each dropped after its ack -> grant order 0,1,2,3; loads in cycles 1,3,5,7; busy continuous.
//  3 Fairness: rr_ptr=2, req=0101 -> requester 2 wins, then requester 0 (wrap); rr_ptr ends at 1.
//  4 arb_en=0 with req=0010 -> no data_on_dr for 10 cycles;
//    arb_en=1 -> load starts on the next cycle.
//  5 Data change after capture: req_data changes 3C->FF during LOAD -> bus_2_dr stays 3C.
//  6 rst=0 asserted mid-LOAD -> data_on_dr, gnt, bus_2_dr go to 0 without a clock edge;
//    after release, req=1000 -> normal grant, no stale ack.

Source files
------------

// File: rtl/dr_load_arbiter_if.sv
// DR load path bundle: requester side (master) and arbiter side (slave).
// Carries requests, per-requester data, grants/acks and the DR load outputs.
interface dr_load_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic              arb_en;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic              data_on_dr;
  logic [DW-1:0]     bus_2_dr;
  logic              busy;

  modport master (
    output arb_en, req, req_data,
    input  gnt, ack, data_on_dr,
    input  bus_2_dr, busy
  );

  modport slave (
    input  arb_en, req, req_data,
    output gnt, ack, data_on_dr,
    output bus_2_dr, busy
  );
endinterface

// File: rtl/dr_load_arbiter.sv
// Round-robin sequencer sharing the DR load path between NREQ requesters.
// IDLE -> LOAD (strobe) -> ACK, with a new capture allowed from ACK.
module dr_load_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic clk,
  input  logic rst,
  dr_load_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACK
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            dod_q, dod_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   rr_q, rr_d;

  logic [NREQ-1:0] req_eff;
  logic [IW:0]     idx;
  logic [IW-1:0]   win;
  logic            found;
  logic            start;

  // ack_q is non-zero only in ACK, so it masks the requester being acked
  always_comb begin
    req_eff = bus.req & ~ack_q;
    found   = 1'b0;
    win     = '0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_q} + (IW+1)'(i);
      if (idx >= (IW+1)'(NREQ))
        idx = idx - (IW+1)'(NREQ);
      if (!found && req_eff[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    start = bus.arb_en && found
            && (state_q != LOAD);
    state_d = state_q;
    gnt_d   = '0;
    ack_d   = '0;
    dod_d   = 1'b0;
    dat_d   = dat_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: state_d = start ? LOAD : IDLE;
      LOAD: state_d = ACK;
      ACK:  state_d = start ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q == LOAD)
      ack_d = gnt_q;
    if (start) begin
      gnt_d[win] = 1'b1;
      dod_d      = 1'b1;
      dat_d      = bus.req_data[win*DW +: DW];
      rr_d       = (win == IW'(NREQ-1))
                   ? '0 : win + 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      dod_q   <= 1'b0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      dod_q   <= dod_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.ack        = ack_q;
  assign bus.data_on_dr = dod_q;
  assign bus.bus_2_dr   = dat_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dr_load_arbiter.sv
// Directed bench for dr_load_arbiter with a load/ack scoreboard.
// Requesters drop req after their ack, as a real requester would.
module tb_dr_load_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  exp_t       expq[$];
  logic [3:0] ackq[$];

  dr_load_arbiter_if #(.NREQ(4), .DW(8)) bus ();

  dr_load_arbiter #(.NREQ(4), .DW(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    logic [3:0] a;
    @(posedge clk);
    #1;
    chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
    chk("ack_onehot0", 32'($onehot0(bus.ack)), 1);
    chk("ack_vs_dod",
        32'((bus.ack != 0) && bus.data_on_dr), 0);
    if (bus.data_on_dr) begin
      if (expq.size() == 0) begin
        chk("unexpected_load", 32'(bus.data_on_dr), 0);
      end else begin
        e = expq.pop_front();
        chk("load_gnt", 32'(bus.gnt), 32'(e.gnt));
        chk("load_data", 32'(bus.bus_2_dr), 32'(e.data));
        ackq.push_back(e.gnt);
      end
    end
    if (bus.ack != 0) begin
      if (ackq.size() == 0) begin
        chk("unexpected_ack", 32'(bus.ack), 0);
      end else begin
        a = ackq.pop_front();
        chk("ack", 32'(bus.ack), 32'(a));
      end
      bus.req = bus.req & ~bus.ack;
    end
  endtask

  task automatic push(input logic [3:0] g,
                      input logic [7:0] d);
    exp_t e;
    e.gnt  = g;
    e.data = d;
    expq.push_back(e);
  endtask

  initial begin
    bus.arb_en   = 1'b0;
    bus.req      = '0;
    bus.req_data = 32'h4433_2211;
    #2 rst = 1'b0;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_dod", 32'(bus.data_on_dr), 0);
    chk("rst_bus", 32'(bus.bus_2_dr), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.arb_en = 1'b1;

    // all four requesting: order 0,1,2,3
    push(4'b0001, 8'h11);
    push(4'b0010, 8'h22);
    push(4'b0100, 8'h33);
    push(4'b1000, 8'h44);
    bus.req = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("b2b_dod_c%0d", k),
          32'(bus.data_on_dr), 32'(k % 2));
      chk($sformatf("b2b_busy_c%0d", k),
          32'(bus.busy), 1);
    end
    tick();
    chk("b2b_idle", 32'(bus.busy), 0);

    // single request
    bus.req_data[7:0] = 8'hA5;
    push(4'b0001, 8'hA5);
    bus.req = 4'b0001;
    tick();
    chk("single_dod", 32'(bus.data_on_dr), 1);
    chk("single_busy", 32'(bus.busy), 1);
    tick();
    chk("single_ack", 32'(bus.ack), 4'b0001);
    chk("single_dod_off", 32'(bus.data_on_dr), 0);
    chk("single_gnt_off", 32'(bus.gnt), 0);
    tick();
    chk("single_idle", 32'(bus.busy), 0);

    // bring rr_ptr to 2, then 0101 wraps 2 -> 0
    push(4'b0010, 8'h22);
    bus.req = 4'b0010;
    repeat (3) tick();
    push(4'b0100, 8'h33);
    push(4'b0001, 8'hA5);
    bus.req = 4'b0101;
    repeat (5) tick();
    chk("fair_idle", 32'(bus.busy), 0);
    // rr_ptr should now be 1: requester 1 beats 0
    push(4'b0010, 8'h22);
    push(4'b0001, 8'hA5);
    bus.req = 4'b0011;
    repeat (5) tick();

    // arb_en gating
    bus.arb_en = 1'b0;
    bus.req    = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("gated_dod", 32'(bus.data_on_dr), 0);
    end
    push(4'b0010, 8'h22);
    bus.arb_en = 1'b1;
    tick();
    chk("ungated_dod", 32'(bus.data_on_dr), 1);
    repeat (2) tick();

    // data changes after capture are ignored
    bus.req_data[23:16] = 8'h3C;
    push(4'b0100, 8'h3C);
    bus.req = 4'b0100;
    tick();
    bus.req_data[23:16] = 8'hFF;
    tick();
    chk("hold_bus_ack", 32'(bus.bus_2_dr), 8'h3C);
    tick();
    chk("hold_bus_idle", 32'(bus.bus_2_dr), 8'h3C);

    // async reset in the middle of LOAD
    bus.req_data[31:24] = 8'h5A;
    push(4'b1000, 8'h5A);
    bus.req = 4'b1000;
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_dod", 32'(bus.data_on_dr), 0);
    chk("arst_gnt", 32'(bus.gnt), 0);
    chk("arst_bus", 32'(bus.bus_2_dr), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    ackq.delete();
    @(negedge clk);
    rst = 1'b1;
    push(4'b1000, 8'h5A);
    tick();
    chk("post_rst_dod", 32'(bus.data_on_dr), 1);
    tick();
    tick();
    chk("post_rst_idle", 32'(bus.busy), 0);
    repeat (2) tick();

    chk("expq_empty", 32'(expq.size()), 0);
    chk("ackq_empty", 32'(ackq.size()), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
